if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port freeze  input  1  hazard stall from ID; holds PC and IF/ID register.
REQ-005 SHALL have port branch_taken  input  1  redirect request from EXE.
REQ-006 SHALL have port branch_addr  input  32  redirect target byte address.
REQ-007 SHALL have port instr_addr  output  32  fetch byte address to instruction memory.
REQ-008 SHALL have port instruction  input  32  word returned combinationally by instruction memory for instr_addr.
REQ-009 SHALL have port if_pc  output  32  registered PC+4 of the fetched word.
REQ-010 SHALL have port if_instruction  output  32  registered fetched word.
REQ-011 SHALL have port if_valid  output  1  registered; 1 = IF/ID holds a real instruction.
REQ-012 SHALL have port fetch_count  output  32  count of instructions delivered to ID.

Function
REQ-013 SHALL drive instr_addr = PC register combinationally; zero-latency memory is assumed by design, and instruction is sampled in the same cycle.
REQ-014 Normal cycle (freeze=0, branch_taken=0): PC <= PC+4; IF/ID <= {PC+4, instruction, valid=1}; fetch_count += 1.
REQ-015 Freeze cycle (freeze=1, branch_taken=0): PC, if_pc, if_instruction, if_valid, fetch_count all hold.
REQ-016 Redirect cycle (branch_taken=1): PC <= {branch_addr[31:2],2'b00}; IF/ID <= {if_pc hold, NOP 32'h0, valid=0}; fetch_count holds.
REQ-017 branch_taken SHALL take priority over freeze in the same cycle; redirect is never lost or deferred.
REQ-018 Fetch addresses SHALL always be word-aligned; branch_addr[1:0] are ignored.
REQ-019 PC+4 SHALL be modulo 2^32: PC=32'hFFFF_FFFC increments to 32'h0000_0000.
REQ-020 fetch_count SHALL wrap modulo 2^32 with no saturation and no flag.
REQ-021 if_pc SHALL be PC+4 of the word it accompanies; ARM PC+8 branch offsets are formed downstream.
REQ-022 There SHALL be no state machine beyond the PC register, IF/ID register and counter; behaviour is fully determined by (freeze, branch_taken) each cycle.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock edge, force PC=RESET_PC, if_pc=0, if_instruction=0, if_valid=0, fetch_count=0.
REQ-024 While rst_n=0, instr_addr SHALL equal RESET_PC; inputs SHALL be ignored.
REQ-025 The first rising edge with rst_n=1 SHALL perform a normal/freeze/redirect update per REQ-014..017.
REQ-026 Reset asserted mid-freeze or mid-redirect SHALL discard the pending effect; no state survives.

Structure
REQ-027 Shared package arm_pkg SHALL hold WORD_W=32, PC_STEP=4, NOP_INSTR=32'h0000_0000.
REQ-028 One sub-module, pc_register (32-bit, load-enable, async active-low reset to parameter), SHALL hold the PC; IF/ID register and counter are inline.

Verification
REQ-029 Reset release, RESET_PC=0, freeze=0, memory word0=32'hE3A0_0014 -> instr_addr 0,4,8 on successive cycles; after first edge if_pc=4, if_instruction=32'hE3A0_0014, if_valid=1, fetch_count=1.
REQ-030 Freeze for 2 cycles while PC=8 -> instr_addr stays 8, if_pc stays 8, fetch_count unchanged; third cycle resumes at 8 then 12.
REQ-031 branch_taken=1, branch_addr=32'h0000_0043, freeze=1 same cycle -> next cycle instr_addr=32'h40, if_valid=0, if_instruction=0, fetch_count unchanged; following cycle if_pc=32'h44, if_valid=1.
REQ-032 RESET_PC=32'hFFFF_FFFC, run 2 cycles -> instr_addr FFFF_FFFC then 0000_0000; first if_pc=0.
REQ-033 rst_n dropped asynchronously between edges mid-run -> all outputs per REQ-023 within the same cycle, before the next clk edge.
REQ-034 Random freeze/branch_taken mix, 10k cycles, against a reference model -> fetch_count equals number of if_valid=1 loads; no mismatch.

Source files
------------

// File: rtl/arm_pkg.sv
// arm_pkg: shared constants and helpers for the fetch stage.
//   WORD_W    : datapath / address width
//   PC_STEP   : byte increment between sequential instruction words
//   NOP_INSTR : bubble word placed in IF/ID on a redirect
package arm_pkg;
    localparam int                 WORD_W    = 32;
    localparam logic [WORD_W-1:0]  PC_STEP   = 32'd4;
    localparam logic [WORD_W-1:0]  NOP_INSTR = 32'h0000_0000;

    // Force a byte address onto a word boundary.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/pc_register.sv
// pc_register: load-enabled program counter with asynchronous active-low
// reset to RESET_VAL.
//   i_clk   : clock (rising edge)
//   i_rst_n : async active-low reset
//   i_load  : 1 = capture i_d this edge
//   i_d     : next PC
//   o_q     : current PC
module pc_register
    import arm_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VAL = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_d,
    output logic [WORD_W-1:0] o_q
);
    logic [WORD_W-1:0] r_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_pc <= RESET_VAL;
        else if (i_load) r_pc <= i_d;
    end

    assign o_q = r_pc;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch. Presents the PC to a zero-latency instruction
// memory, captures the returned word with PC+4 into the IF/ID register, and
// counts delivered instructions.
//   clk, rst_n      : clock, async active-low reset
//   freeze          : ID hazard stall; holds PC, IF/ID and counter
//   branch_taken    : EXE redirect; wins over freeze, inserts a bubble
//   branch_addr     : redirect target (low two bits ignored)
//   instr_addr      : fetch address (= PC)
//   instruction     : memory word for instr_addr, same cycle
//   if_pc           : PC+4 of the word in IF/ID
//   if_instruction  : word in IF/ID
//   if_valid        : IF/ID holds a real instruction
//   fetch_count     : instructions delivered to ID (wraps)
module if_stage
    import arm_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_addr,
    output logic [WORD_W-1:0] instr_addr,
    input  logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] if_pc,
    output logic [WORD_W-1:0] if_instruction,
    output logic              if_valid,
    output logic [WORD_W-1:0] fetch_count
);
    logic [WORD_W-1:0] w_pc;
    logic [WORD_W-1:0] w_pc_plus4;
    logic [WORD_W-1:0] w_pc_next;
    logic              w_pc_load;

    logic [WORD_W-1:0] r_if_pc;
    logic [WORD_W-1:0] r_if_instr;
    logic              r_if_valid;
    logic [WORD_W-1:0] r_fetch_cnt;

    // Wraps naturally at 2^32.
    assign w_pc_plus4 = w_pc + PC_STEP;
    // A redirect must never be swallowed by a stall, so it also loads the PC.
    assign w_pc_load  = branch_taken | ~freeze;
    assign w_pc_next  = branch_taken ? word_align(branch_addr) : w_pc_plus4;

    pc_register #(.RESET_VAL(RESET_PC)) u_pc (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_load  (w_pc_load),
        .i_d     (w_pc_next),
        .o_q     (w_pc)
    );

    assign instr_addr = w_pc;

    // IF/ID register and delivered-instruction counter. On a redirect the
    // word fetched this cycle is on the wrong path: replace it with a bubble
    // and leave if_pc untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_pc     <= '0;
            r_if_instr  <= '0;
            r_if_valid  <= 1'b0;
            r_fetch_cnt <= '0;
        end else if (branch_taken) begin
            r_if_instr  <= NOP_INSTR;
            r_if_valid  <= 1'b0;
        end else if (!freeze) begin
            r_if_pc     <= w_pc_plus4;
            r_if_instr  <= instruction;
            r_if_valid  <= 1'b1;
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign if_pc          = r_if_pc;
    assign if_instruction = r_if_instr;
    assign if_valid       = r_if_valid;
    assign fetch_count    = r_fetch_cnt;
endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        freeze, branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] instr_addr, instruction, if_pc, if_instruction, fetch_count;
    logic        if_valid;
    logic [31:0] instr_addr2, instruction2, if_pc2, if_instruction2, fetch_count2;
    logic        if_valid2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ins;
        logic        vld;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb[$];

    // reference model state
    logic [31:0] m_pc, m_ifpc, m_ins, m_cnt;
    logic        m_vld;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_0014;
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    assign instruction  = mem(instr_addr);
    assign instruction2 = mem(instr_addr2);

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .instr_addr(instr_addr), .instruction(instruction),
        .if_pc(if_pc), .if_instruction(if_instruction), .if_valid(if_valid),
        .fetch_count(fetch_count)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst2_n), .freeze(1'b0), .branch_taken(1'b0),
        .branch_addr(32'h0), .instr_addr(instr_addr2), .instruction(instruction2),
        .if_pc(if_pc2), .if_instruction(if_instruction2), .if_valid(if_valid2),
        .fetch_count(fetch_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ifpc = 32'h0; m_ins = 32'h0; m_vld = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".addr"},  instr_addr,     m_pc);
        chk({tag, ".if_pc"}, if_pc,          m_ifpc);
        chk({tag, ".ins"},   if_instruction, m_ins);
        chk({tag, ".vld"},   {31'h0, if_valid}, {31'h0, m_vld});
        chk({tag, ".cnt"},   fetch_count,    m_cnt);
    endtask

    // Called just after a negedge: drive, predict, clock, compare.
    task automatic step(input string tag, input logic f, input logic b, input logic [31:0] a);
        exp_t e;
        freeze = f; branch_taken = b; branch_addr = a;
        #1;
        chk({tag, ".pre_addr"}, instr_addr, m_pc);
        if (b) begin
            m_ins = 32'h0; m_vld = 1'b0;
            m_pc  = {a[31:2], 2'b00};
        end else if (!f) begin
            m_ifpc = m_pc + 32'd4;
            m_ins  = mem(m_pc);
            m_vld  = 1'b1;
            m_cnt  = m_cnt + 32'd1;
            m_pc   = m_pc + 32'd4;
        end
        e.pc = m_pc; e.ifpc = m_ifpc; e.ins = m_ins; e.vld = m_vld; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".addr"},  instr_addr,        e.pc);
            chk({tag, ".if_pc"}, if_pc,             e.ifpc);
            chk({tag, ".ins"},   if_instruction,    e.ins);
            chk({tag, ".vld"},   {31'h0, if_valid}, {31'h0, e.vld});
            chk({tag, ".cnt"},   fetch_count,       e.cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        model_reset();

        // reset state, with a clock edge and noisy inputs while held
        @(negedge clk);
        chk_state("rst0");
        freeze = 1'b0; branch_taken = 1'b1; branch_addr = 32'h0000_1234;
        @(negedge clk);
        chk_state("rst_hold");
        branch_taken = 1'b0;

        // release; sequential fetch 0,4,8
        rst_n = 1'b1;
        step("run0", 1'b0, 1'b0, 32'h0);
        chk("run0.first_word", if_instruction, 32'hE3A0_0014);
        step("run1", 1'b0, 1'b0, 32'h0);

        // two freeze cycles at PC=8, then resume
        step("frz0", 1'b1, 1'b0, 32'h0);
        step("frz1", 1'b1, 1'b0, 32'h0);
        step("frz_res0", 1'b0, 1'b0, 32'h0);
        step("frz_res1", 1'b0, 1'b0, 32'h0);

        // redirect wins over freeze, misaligned target
        step("br_frz", 1'b1, 1'b1, 32'h0000_0043);
        chk("br_frz.addr40", instr_addr, 32'h0000_0040);
        step("br_after", 1'b0, 1'b0, 32'h0);
        chk("br_after.if_pc44", if_pc, 32'h0000_0044);

        // back-to-back redirects, then redirect right after freeze
        step("br2a", 1'b0, 1'b1, 32'h0000_0102);
        step("br2b", 1'b0, 1'b1, 32'h0000_0201);
        step("br2c", 1'b1, 1'b0, 32'h0);
        step("br2d", 1'b0, 1'b0, 32'h0);

        // async reset between edges, mid-redirect
        freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h0000_0800;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_state("async_rst");
        @(negedge clk);
        chk_state("async_rst_hold");
        freeze = 1'b0; branch_taken = 1'b0;
        rst_n = 1'b1;
        step("post_rst", 1'b0, 1'b0, 32'h0);

        // random mix against the model
        for (int i = 0; i < 10000; i++) begin
            logic f, b;
            f = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            step("rnd", f, b, $urandom);
        end

        // PC wrap with RESET_PC = FFFF_FFFC
        rst2_n = 1'b1;
        #1;
        chk("wrap.addr0", instr_addr2, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        chk("wrap.addr1", instr_addr2, 32'h0000_0000);
        chk("wrap.if_pc", if_pc2, 32'h0000_0000);
        chk("wrap.ins", if_instruction2, mem(32'hFFFF_FFFC));
        chk("wrap.vld", {31'h0, if_valid2}, 32'h1);
        chk("wrap.cnt", fetch_count2, 32'h1);
        @(posedge clk); #1;
        chk("wrap.addr2", instr_addr2, 32'h0000_0004);
        chk("wrap.if_pc2", if_pc2, 32'h0000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
